csr_unit: RTL and testbench
===========================

// Module: csr_unit
// PURPOSE
//  Machine-mode CSR file, successor of the fixed 32-bit CSR bank: adds atomic CSRRW/S/C, trap entry and
//  MRET sequencing, instret counting, live interrupt-pending evaluation and vectored mtvec.
//  Sits beside the execute stage; the decoder issues one CSR access per cycle, the trap controller drives trap/mret.
// PARAMETERS
//  XLEN         32      register width (32 only validated; all CSR regs are XLEN)
//  CNT_W        64      width of mcycle/minstret (33..64); upper half read via *h address, zero-extended
//  MTVEC_RST    32'h0   reset value of mtvec
//  HART_ID      0       value returned by mhartid
//  VECTORED_EN  1       1: mtvec.MODE=1 honoured; 0: MODE bits read as 0, writes ignored
// PORTS
//  clk          in   1     clock
//  rst          in   1     synchronous active-high reset
//  csr_valid    in   1     access request this cycle
//  csr_op       in   2     01 RW, 10 RS (set), 11 RC (clear), 00 read-only
//  csr_addr     in   12    CSR address
//  csr_wdata    in   XLEN  write/mask operand
//  csr_rdata    out  XLEN  pre-write value of csr_addr, registered (1 cycle)
//  csr_illegal  out  1     registered, 1-cycle pulse: access rejected
//  instret_inc  in   1     one instruction retired this cycle
//  trap_req     in   1     take trap this cycle
//  trap_cause   in   XLEN  mcause value (bit XLEN-1 = interrupt)
//  trap_pc      in   XLEN  pc to save in mepc
//  trap_tval    in   XLEN  value for mtval
//  mret_req     in   1     execute MRET this cycle
//  irq_ext/irq_tmr/irq_sw in 1 level interrupt sources
//  trap_vec     out  XLEN  combinational handler target from mtvec and trap_cause
//  mepc_out     out  XLEN  current mepc (MRET target)
//  irq_pending  out  1     mstatus.MIE & |(mip & mie), registered
//  glb_int_en   out  1     mstatus.MIE
// BEHAVIOUR
//  - Reset: mtvec=MTVEC_RST, all other CSRs, counters, csr_rdata, csr_illegal, irq_pending = 0.
//  - Write value: RW=wdata; RS=old|wdata; RC=old&~wdata. RS/RC with wdata==0 and op 00 never write.
//  - csr_rdata: value before this cycle's update, valid cycle after csr_valid; held when csr_valid=0.
//  - Illegal (no state change, rdata=0): unimplemented address; any write to addr[11:10]==2'b11
//    (cycle 0xC00, instret 0xC02, cycleh 0xC80, instreth 0xC82, mhartid 0xF14 are read-only).
//  - Implemented: mstatus 0x300 (only MIE b3, MPIE b7 stored; rest read 0), mie 0x304 (bits 11,7,3),
//    mtvec 0x305, mscratch 0x340, mepc 0x341 (bits[1:0] read 0), mcause 0x342, mtval 0x343,
//    mip 0x344 (read-only view, writes ignored not illegal), mcycle/h 0xB00/0xB80, minstret/h 0xB02/0xB82.
//  - mip: MEIP b11, MTIP b7, MSIP b3 = irq inputs registered once (1-cycle latency to irq_pending).
//  - Priority in one cycle: trap_req > mret_req > csr write. Trap: mepc<=trap_pc, mcause<=trap_cause,
//    mtval<=trap_tval, MPIE<=MIE, MIE<=0. MRET: MIE<=MPIE, MPIE<=1. A CSR write colliding with either is dropped.
//  - trap_vec: base=mtvec&~3; interrupt cause and MODE==1 -> base+4*cause[XLEN-2:0]; else base.
//  - Counters: mcycle +1 every cycle; minstret +1 on instret_inc; both wrap at 2^CNT_W silently.
//    Write to low/high half replaces those bits only; write wins over same-cycle increment.
// STRUCTURE
//  - Shared package (defines): CSR addresses, csr_op encodings, mcause codes, mip/mie bit indices.
//  - Sub-module csr_counter (CNT_W, inc, wr_lo, wr_hi, wdata, value) instantiated twice.
// TESTING
//  - RS 0x304 wdata=0x888 after RW 0x80 -> rdata 0x80, then read 0x888; RC 0x8 -> reads 0x880.
//  - Write 0xC00 -> csr_illegal=1, rdata=0, mcycle unchanged; RS 0xC00 wdata=0 -> legal read.
//  - MIE=1, mie=0x80, irq_tmr=1 -> irq_pending=1 two cycles later; trap cause 0x80000007, mtvec 0x1001
//    -> trap_vec 0x101C, MIE=0, MPIE=1; MRET -> MIE=1.
//  - trap_req with same-cycle RW mepc=0x40 -> mepc=trap_pc; write dropped.
//  - Write mcycle=0xFFFFFFFF, mcycleh=0 -> two cycles later cycleh reads 1; write coinciding with wrap wins.
//  - Reset mid-trap: mepc, mcause, MIE, counters all read 0, mtvec reads MTVEC_RST.

Source files
------------

// File: rtl/csr_unit_pkg.sv
// csr_unit_pkg: CSR addresses, access opcodes, mcause codes and interrupt bit positions
package csr_unit_pkg;
  typedef enum logic [1:0] {OP_RD = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11} csr_op_e;
  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_INSTRET  = 12'hC02;
  localparam logic [11:0] A_CYCLEH   = 12'hC80;
  localparam logic [11:0] A_INSTRETH = 12'hC82;
  localparam logic [11:0] A_MHARTID  = 12'hF14;
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MSI_BIT  = 3;
  localparam int MTI_BIT  = 7;
  localparam int MEI_BIT  = 11;
  localparam logic [31:0] IRQ_MASK    = 32'h0000_0888;
  localparam logic [31:0] CAUSE_MSI   = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI   = 32'h8000_0007;
  localparam logic [31:0] CAUSE_MEI   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_ILL   = 32'h0000_0002;
  localparam logic [31:0] CAUSE_ECALL = 32'h0000_000B;
endpackage

// File: rtl/csr_unit_counter.sv
// csr_counter: wide free-running counter with independently writable low/high XLEN halves
module csr_counter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [XLEN-1:0]  wdata,
  output logic [CNT_W-1:0] value
);
  // a write to either half suppresses the increment for the whole counter that cycle
  always_ff @(posedge clk) begin
    if (rst) value <= '0;
    else if (wr_lo || wr_hi) begin
      if (wr_lo) value[XLEN-1:0] <= wdata;
      if (wr_hi) value[CNT_W-1:XLEN] <= wdata[CNT_W-XLEN-1:0];
    end else value <= value + CNT_W'(inc);
  end
endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with atomic RW/RS/RC, trap/MRET sequencing, counters and vectored mtvec
module csr_unit
  import csr_unit_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              CNT_W       = 64,
  parameter logic [XLEN-1:0] MTVEC_RST   = '0,
  parameter logic [XLEN-1:0] HART_ID     = '0,
  parameter bit              VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_valid,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            instret_inc,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_req,
  input  logic            irq_ext,
  input  logic            irq_tmr,
  input  logic            irq_sw,
  output logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] mepc_out,
  output logic            irq_pending,
  output logic            glb_int_en
);
  localparam logic [XLEN-1:0] LO2 = XLEN'(3);
  logic mst_mie, mst_mpie, hit, is_wr, illegal, wr_en;
  logic [XLEN-1:0] mie_r, mip_r, mtvec, mscratch, mepc, mcause, mtval, old, nv, base;
  logic [CNT_W-1:0] mcycle, minstret;
  logic [2*XLEN-1:0] cyc_x, ins_x;
  assign cyc_x = (2*XLEN)'(mcycle);
  assign ins_x = (2*XLEN)'(minstret);
  always_comb begin
    hit = 1'b1;
    old = '0;
    case (csr_addr)
      A_MSTATUS: begin
        old[MPIE_BIT] = mst_mpie;
        old[MIE_BIT] = mst_mie;
      end
      A_MIE:                   old = mie_r;
      A_MTVEC:                 old = mtvec;
      A_MSCRATCH:              old = mscratch;
      A_MEPC:                  old = mepc;
      A_MCAUSE:                old = mcause;
      A_MTVAL:                 old = mtval;
      A_MIP:                   old = mip_r;
      A_MCYCLE, A_CYCLE:       old = cyc_x[XLEN-1:0];
      A_MCYCLEH, A_CYCLEH:     old = cyc_x[2*XLEN-1:XLEN];
      A_MINSTRET, A_INSTRET:   old = ins_x[XLEN-1:0];
      A_MINSTRETH, A_INSTRETH: old = ins_x[2*XLEN-1:XLEN];
      A_MHARTID:               old = HART_ID;
      default:                 hit = 1'b0;
    endcase
  end
  assign is_wr = csr_op == OP_RW || (csr_op != OP_RD && csr_wdata != '0);
  assign illegal = !hit || (is_wr && csr_addr[11:10] == 2'b11);
  assign wr_en = csr_valid && !illegal && is_wr && !trap_req && !mret_req;
  assign nv = csr_op == OP_RW ? csr_wdata : csr_op == OP_RS ? old | csr_wdata : old & ~csr_wdata;
  assign base = mtvec & ~LO2;
  assign trap_vec = (VECTORED_EN && trap_cause[XLEN-1] && mtvec[1:0] == 2'b01)
                    ? base + {trap_cause[XLEN-3:0], 2'b00} : base;
  assign mepc_out = mepc;
  assign glb_int_en = mst_mie;
  // trap beats MRET beats the decoder's write; a colliding write is simply lost
  always_ff @(posedge clk) begin
    if (rst) begin
      {mst_mie, mst_mpie, csr_illegal, irq_pending} <= '0;
      {mie_r, mip_r, mscratch, mepc, mcause, mtval, csr_rdata} <= '0;
      mtvec <= MTVEC_RST;
    end else begin
      mip_r[MEI_BIT] <= irq_ext;
      mip_r[MTI_BIT] <= irq_tmr;
      mip_r[MSI_BIT] <= irq_sw;
      irq_pending <= mst_mie && |(mip_r & mie_r);
      if (csr_valid) csr_rdata <= illegal ? '0 : old;
      csr_illegal <= csr_valid && illegal;
      if (trap_req) begin
        mepc <= trap_pc & ~LO2;
        mcause <= trap_cause;
        mtval <= trap_tval;
        mst_mpie <= mst_mie;
        mst_mie <= 1'b0;
      end else if (mret_req) begin
        mst_mie <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (wr_en) begin
        case (csr_addr)
          A_MSTATUS: begin
            mst_mie <= nv[MIE_BIT];
            mst_mpie <= nv[MPIE_BIT];
          end
          A_MIE:      mie_r <= nv & XLEN'(IRQ_MASK);
          A_MTVEC:    mtvec <= VECTORED_EN ? nv : nv & ~LO2;
          A_MSCRATCH: mscratch <= nv;
          A_MEPC:     mepc <= nv & ~LO2;
          A_MCAUSE:   mcause <= nv;
          A_MTVAL:    mtval <= nv;
          default: ;
        endcase
      end
    end
  end
  csr_counter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_mcycle (
    .clk(clk), .rst(rst), .inc(1'b1),
    .wr_lo(wr_en && csr_addr == A_MCYCLE), .wr_hi(wr_en && csr_addr == A_MCYCLEH),
    .wdata(nv), .value(mcycle)
  );
  csr_counter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_minstret (
    .clk(clk), .rst(rst), .inc(instret_inc),
    .wr_lo(wr_en && csr_addr == A_MINSTRET), .wr_hi(wr_en && csr_addr == A_MINSTRETH),
    .wdata(nv), .value(minstret)
  );
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed scoreboard bench for csr_unit
module tb_csr_unit;
  import csr_unit_pkg::*;
  logic clk, rst, csr_valid, csr_illegal, instret_inc, trap_req, mret_req;
  logic irq_ext, irq_tmr, irq_sw, irq_pending, glb_int_en;
  logic [1:0] csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, trap_cause, trap_pc, trap_tval, trap_vec, mepc_out;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [31:0] rdata;
    logic        ill;
    bit          ck;
    string       tag;
  } exp_t;
  exp_t exp_q[$];

  csr_unit dut (
    .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .instret_inc(instret_inc), .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_tval(trap_tval), .mret_req(mret_req), .irq_ext(irq_ext), .irq_tmr(irq_tmr),
    .irq_sw(irq_sw), .trap_vec(trap_vec), .mepc_out(mepc_out), .irq_pending(irq_pending),
    .glb_int_en(glb_int_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [31:0] erd, input logic eill, input bit ck, input string tag);
    exp_t e;
    csr_valid = 1'b1;
    csr_op = op;
    csr_addr = addr;
    csr_wdata = wd;
    e.rdata = erd;
    e.ill = eill;
    e.ck = ck;
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    csr_valid = 1'b0;
    csr_op = 2'b00;
    csr_wdata = '0;
    e = exp_q.pop_front();
    if (e.ck) chk({e.tag, ".rdata"}, csr_rdata, e.rdata);
    chk({e.tag, ".illegal"}, 32'(csr_illegal), 32'(e.ill));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {csr_valid, instret_inc, trap_req, mret_req, irq_ext, irq_tmr, irq_sw} = '0;
    csr_op = 2'b00;
    csr_addr = '0;
    {csr_wdata, trap_cause, trap_pc, trap_tval} = '0;
    tick(3);
    chk("rst.rdata", csr_rdata, 32'h0);
    chk("rst.illegal", 32'(csr_illegal), 32'h0);
    chk("rst.irq_pending", 32'(irq_pending), 32'h0);
    chk("rst.glb_int_en", 32'(glb_int_en), 32'h0);
    chk("rst.mepc", mepc_out, 32'h0);
    chk("rst.trap_vec", trap_vec, 32'h0);
    rst = 1'b0;
    access(OP_RW, A_MIE, 32'h80, 32'h0, 1'b0, 1'b1, "mie_rw");
    access(OP_RS, A_MIE, 32'h888, 32'h80, 1'b0, 1'b1, "mie_rs");
    access(OP_RD, A_MIE, 32'h0, 32'h888, 1'b0, 1'b1, "mie_rd1");
    access(OP_RC, A_MIE, 32'h8, 32'h888, 1'b0, 1'b1, "mie_rc");
    access(OP_RD, A_MIE, 32'h0, 32'h880, 1'b0, 1'b1, "mie_rd2");
    access(OP_RW, A_MCYCLE, 32'h100, 32'h0, 1'b0, 1'b0, "mcycle_set");
    access(OP_RW, A_CYCLE, 32'h1234, 32'h0, 1'b1, 1'b1, "cycle_wr_ill");
    access(OP_RS, A_CYCLE, 32'h0, 32'h101, 1'b0, 1'b1, "cycle_rs0");
    access(OP_RD, A_MCYCLE, 32'h0, 32'h102, 1'b0, 1'b1, "mcycle_rd");
    access(OP_RW, A_MTVEC, 32'h1001, 32'h0, 1'b0, 1'b1, "mtvec_wr");
    access(OP_RW, A_MSTATUS, 32'h8, 32'h0, 1'b0, 1'b1, "mstatus_mie");
    access(OP_RW, A_MIE, 32'h80, 32'h880, 1'b0, 1'b1, "mie_tmr");
    irq_tmr = 1'b1;
    tick(1);
    chk("irq_pending.lat1", 32'(irq_pending), 32'h0);
    tick(1);
    chk("irq_pending.lat2", 32'(irq_pending), 32'h1);
    chk("glb_int_en.on", 32'(glb_int_en), 32'h1);
    access(OP_RD, A_MIP, 32'h0, 32'h80, 1'b0, 1'b1, "mip_rd");
    trap_req = 1'b1;
    trap_cause = CAUSE_MTI;
    trap_pc = 32'h200;
    trap_tval = 32'hAB;
    #1;
    chk("trap_vec.vectored", trap_vec, 32'h101C);
    tick(1);
    trap_req = 1'b0;
    chk("trap.glb_int_en", 32'(glb_int_en), 32'h0);
    chk("trap.mepc", mepc_out, 32'h200);
    access(OP_RD, A_MSTATUS, 32'h0, 32'h80, 1'b0, 1'b1, "trap_mstatus");
    chk("trap.irq_pending_off", 32'(irq_pending), 32'h0);
    access(OP_RD, A_MCAUSE, 32'h0, CAUSE_MTI, 1'b0, 1'b1, "trap_mcause");
    access(OP_RD, A_MTVAL, 32'h0, 32'hAB, 1'b0, 1'b1, "trap_mtval");
    mret_req = 1'b1;
    tick(1);
    mret_req = 1'b0;
    chk("mret.glb_int_en", 32'(glb_int_en), 32'h1);
    access(OP_RD, A_MSTATUS, 32'h0, 32'h88, 1'b0, 1'b1, "mret_mstatus");
    irq_tmr = 1'b0;
    trap_cause = CAUSE_ILL;
    #1;
    chk("trap_vec.exception", trap_vec, 32'h1000);
    trap_req = 1'b1;
    trap_pc = 32'h300;
    access(OP_RW, A_MEPC, 32'h40, 32'h200, 1'b0, 1'b1, "mepc_collide");
    trap_req = 1'b0;
    chk("collide.mepc", mepc_out, 32'h300);
    access(OP_RW, A_MEPC, 32'h43, 32'h300, 1'b0, 1'b1, "mepc_wr");
    access(OP_RD, A_MEPC, 32'h0, 32'h40, 1'b0, 1'b1, "mepc_align");
    access(OP_RW, A_MIP, 32'h888, 32'h0, 1'b0, 1'b1, "mip_wr_ignored");
    access(OP_RD, A_MIP, 32'h0, 32'h0, 1'b0, 1'b1, "mip_rd0");
    access(OP_RD, 12'h7C0, 32'h0, 32'h0, 1'b1, 1'b1, "unimpl_rd");
    access(OP_RD, A_MHARTID, 32'h0, 32'h0, 1'b0, 1'b1, "hartid_rd");
    access(OP_RW, A_MHARTID, 32'h1, 32'h0, 1'b1, 1'b1, "hartid_wr");
    access(OP_RW, A_MCYCLE, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, "mcycle_max");
    access(OP_RW, A_MCYCLEH, 32'h0, 32'h0, 1'b0, 1'b1, "mcycleh_wr");
    tick(1);
    access(OP_RD, A_MCYCLEH, 32'h0, 32'h1, 1'b0, 1'b1, "mcycleh_carry");
    access(OP_RD, A_CYCLEH, 32'h0, 32'h1, 1'b0, 1'b1, "cycleh_carry");
    access(OP_RW, A_MCYCLE, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, "mcycle_max2");
    access(OP_RW, A_MCYCLE, 32'h5, 32'hFFFF_FFFF, 1'b0, 1'b1, "mcycle_wrapwr");
    access(OP_RD, A_MCYCLE, 32'h0, 32'h5, 1'b0, 1'b1, "mcycle_wins");
    access(OP_RD, A_MCYCLEH, 32'h0, 32'h1, 1'b0, 1'b1, "mcycleh_nocarry");
    access(OP_RW, A_MINSTRET, 32'h10, 32'h0, 1'b0, 1'b1, "minstret_wr");
    instret_inc = 1'b1;
    tick(3);
    instret_inc = 1'b0;
    access(OP_RD, A_INSTRET, 32'h0, 32'h13, 1'b0, 1'b1, "instret_cnt");
    instret_inc = 1'b1;
    access(OP_RW, A_MINSTRET, 32'h50, 32'h13, 1'b0, 1'b1, "minstret_wr_inc");
    instret_inc = 1'b0;
    access(OP_RD, A_MINSTRET, 32'h0, 32'h50, 1'b0, 1'b1, "minstret_wins");
    access(OP_RW, A_MSTATUS, 32'h8, 32'h80, 1'b0, 1'b1, "pre_rst_mie");
    trap_req = 1'b1;
    trap_cause = CAUSE_ECALL;
    trap_pc = 32'h500;
    rst = 1'b1;
    tick(1);
    trap_req = 1'b0;
    tick(1);
    chk("rst2.glb_int_en", 32'(glb_int_en), 32'h0);
    chk("rst2.mepc", mepc_out, 32'h0);
    chk("rst2.irq_pending", 32'(irq_pending), 32'h0);
    chk("rst2.rdata", csr_rdata, 32'h0);
    rst = 1'b0;
    access(OP_RD, A_MCYCLE, 32'h0, 32'h0, 1'b0, 1'b1, "rst2_mcycle");
    access(OP_RD, A_MINSTRET, 32'h0, 32'h0, 1'b0, 1'b1, "rst2_minstret");
    access(OP_RD, A_MEPC, 32'h0, 32'h0, 1'b0, 1'b1, "rst2_mepc");
    access(OP_RD, A_MCAUSE, 32'h0, 32'h0, 1'b0, 1'b1, "rst2_mcause");
    access(OP_RD, A_MTVEC, 32'h0, 32'h0, 1'b0, 1'b1, "rst2_mtvec");
    access(OP_RD, A_MSTATUS, 32'h0, 32'h0, 1'b0, 1'b1, "rst2_mstatus");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
